// File: rtl/addr_region_checker_pkg.sv
// Shared region/cause/size codes for the address region checker.
package addr_check_pkg;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_RAM  = 2'd1,
    REG_ROM  = 2'd2,
    REG_IO   = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_UNMAPPED = 2'd1,
    CAUSE_ROMWR    = 2'd2,
    CAUSE_MISALIGN = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'd0,
    SIZE_HALF   = 2'd1,
    SIZE_WORD   = 2'd2,
    SIZE_DOUBLE = 2'd3
  } size_e;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: align_mask = 3'b000;
      SIZE_HALF: align_mask = 3'b001;
      SIZE_WORD: align_mask = 3'b011;
      default:   align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/addr_region_checker_if.sv
// Request/response and fault-record bundle for addr_region_checker.
interface addr_region_checker_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  fault_clear;

  logic                  rsp_valid;
  logic [1:0]            rsp_region;
  logic                  rsp_fault;
  logic [1:0]            rsp_cause;
  logic                  fault_sticky;
  logic [ADDR_WIDTH-1:0] fault_addr;
  logic [1:0]            fault_cause;
  logic [CNT_WIDTH-1:0]  fault_count;

  modport master (
    output req_valid, req_addr, req_write, req_size, fault_clear,
    input  rsp_valid, rsp_region, rsp_fault, rsp_cause,
    input  fault_sticky, fault_addr, fault_cause, fault_count
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_size, fault_clear,
    output rsp_valid, rsp_region, rsp_fault, rsp_cause,
    output fault_sticky, fault_addr, fault_cause, fault_count
  );
endinterface

// File: rtl/addr_region_checker_region_match.sv
// Combinational window match: full-width compare of the address above BITS.
module region_match #(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
  parameter int unsigned           BITS       = 8
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit
);
  assign hit = ((addr >> BITS) == (BASE >> BITS));
endmodule

// File: rtl/addr_region_checker.sv
// Registered RAM/ROM/IO address classifier with a sticky first-fault record.
// ALIGN_CHECK_EN enables the misaligned-access cause.
module addr_region_checker
  import addr_check_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = '0,
  parameter int unsigned           RAM_BITS   = 8,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = 64'h0000_0000_0001_0000,
  parameter int unsigned           ROM_BITS   = 10,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 64'hF000_0000_0000_0000,
  parameter int unsigned           IO_BITS    = 4,
  parameter int unsigned           CNT_WIDTH  = 8
) (
  input logic             clock,
  input logic             reset,
  addr_region_checker_if.slave bus
);

  logic hit_ram, hit_rom, hit_io;

  region_match #(.ADDR_WIDTH(ADDR_WIDTH), .BASE(RAM_BASE), .BITS(RAM_BITS)) u_ram (
    .addr(bus.req_addr), .hit(hit_ram));
  region_match #(.ADDR_WIDTH(ADDR_WIDTH), .BASE(ROM_BASE), .BITS(ROM_BITS)) u_rom (
    .addr(bus.req_addr), .hit(hit_rom));
  region_match #(.ADDR_WIDTH(ADDR_WIDTH), .BASE(IO_BASE), .BITS(IO_BITS)) u_io (
    .addr(bus.req_addr), .hit(hit_io));

  logic                  rsp_valid_q;
  region_e               rsp_region_q, region_d;
  cause_e                rsp_cause_q, cause_d;
  logic                  sticky_q, sticky_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  cause_e                fcause_q, fcause_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  fault_now;

`ifndef ALIGN_CHECK_EN
  logic unused_size;
  assign unused_size = ^bus.req_size;
`endif

  always_comb begin
    region_d = REG_NONE;
    cause_d  = CAUSE_NONE;
    if (bus.req_valid) begin
      if (hit_ram)      region_d = REG_RAM;
      else if (hit_rom) region_d = REG_ROM;
      else if (hit_io)  region_d = REG_IO;

      if (region_d == REG_NONE)
        cause_d = CAUSE_UNMAPPED;
      else if (region_d == REG_ROM && bus.req_write)
        cause_d = CAUSE_ROMWR;
`ifdef ALIGN_CHECK_EN
      else if ((bus.req_addr[2:0] & align_mask(bus.req_size)) != 3'b000)
        cause_d = CAUSE_MISALIGN;
`endif
    end
  end

  assign fault_now = (cause_d != CAUSE_NONE);

  // A fault on the same edge as fault_clear starts a fresh record.
  always_comb begin
    sticky_d = sticky_q;
    faddr_d  = faddr_q;
    fcause_d = fcause_q;
    count_d  = count_q;
    if (fault_now) begin
      if (!sticky_q || bus.fault_clear) begin
        sticky_d = 1'b1;
        faddr_d  = bus.req_addr;
        fcause_d = cause_d;
      end
      if (bus.fault_clear)
        count_d = CNT_WIDTH'(1);
      else if (count_q != {CNT_WIDTH{1'b1}})
        count_d = count_q + CNT_WIDTH'(1);
    end else if (bus.fault_clear) begin
      sticky_d = 1'b0;
      faddr_d  = '0;
      fcause_d = CAUSE_NONE;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_region_q <= REG_NONE;
      rsp_cause_q  <= CAUSE_NONE;
      sticky_q     <= 1'b0;
      faddr_q      <= '0;
      fcause_q     <= CAUSE_NONE;
      count_q      <= '0;
    end else begin
      rsp_valid_q  <= bus.req_valid;
      rsp_region_q <= region_d;
      rsp_cause_q  <= cause_d;
      sticky_q     <= sticky_d;
      faddr_q      <= faddr_d;
      fcause_q     <= fcause_d;
      count_q      <= count_d;
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_region   = rsp_region_q;
  assign bus.rsp_cause    = rsp_cause_q;
  assign bus.rsp_fault    = (rsp_cause_q != CAUSE_NONE);
  assign bus.fault_sticky = sticky_q;
  assign bus.fault_addr   = faddr_q;
  assign bus.fault_cause  = fcause_q;
  assign bus.fault_count  = count_q;

endmodule

// File: doc/addr_region_checker.md
Name: addr_region_checker

Overview:
- Parametrised, registered successor to the single-window RAM address check in the LegV8 datapath.
- Classifies each memory request address into RAM, ROM or IO windows, or a fault.
- Flags ROM writes and, optionally, misaligned accesses.
- Holds a sticky fault record (first faulting address, cause, saturating count) for the control unit and debug.

Parameters:
ADDR_WIDTH, 64, request address width
RAM_BASE, 0, RAM window base; must be aligned to 2^RAM_BITS
RAM_BITS, 8, RAM window size is 2^RAM_BITS bytes
ROM_BASE, 64'h0000_0000_0001_0000, ROM window base; aligned to 2^ROM_BITS
ROM_BITS, 10, ROM window size is 2^ROM_BITS bytes
IO_BASE, 64'hF000_0000_0000_0000, IO window base; aligned to 2^IO_BITS
IO_BITS, 4, IO window size is 2^IO_BITS bytes
CNT_WIDTH, 8, fault counter width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  request present this cycle
req_addr  in  ADDR_WIDTH  byte address
req_write  in  1  1 = store, 0 = load
req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double
fault_clear  in  1  clears the sticky fault record
rsp_valid  out  1  registered response strobe
rsp_region  out  2  0 = none/fault, 1 = RAM, 2 = ROM, 3 = IO
rsp_fault  out  1  this response is a fault
rsp_cause  out  2  0 = none, 1 = unmapped, 2 = ROM write, 3 = misaligned
fault_sticky  out  1  at least one fault since the last clear or reset
fault_addr  out  ADDR_WIDTH  address of the first fault since clear
fault_cause  out  2  cause of the first fault since clear
fault_count  out  CNT_WIDTH  faults since clear, saturating

Behaviour:
- Reset is sampled on the rising edge of clock while reset == 0. All outputs go to 0.
- Window match: an address is in a window when (req_addr >> BITS) == (BASE >> BITS). Full ADDR_WIDTH comparison; upper bits are never ignored.
- Windows must not overlap. If they do, priority is RAM > ROM > IO.
- Latency is exactly 1 cycle. rsp_* reflect the request sampled on the previous edge.
- rsp_valid = registered req_valid. There is no backpressure; a new request is accepted every cycle.
- When rsp_valid == 0: rsp_region, rsp_fault and rsp_cause are 0.
- Cause priority:
  - unmapped (no window hit): rsp_region = 0
  - else ROM write (rsp_region stays 2)
  - else misaligned (feature only)
  - else none
- rsp_fault = (rsp_cause != 0).
- Sticky record update, on the same edge as the response register:
  - Fault while fault_sticky == 0: capture fault_addr and fault_cause, set fault_sticky.
  - Any fault: fault_count increments and saturates at 2^CNT_WIDTH-1.
  - Later faults leave fault_addr and fault_cause unchanged.
- fault_clear alone: fault_sticky, fault_addr, fault_cause and fault_count go to 0 on the next edge.
- fault_clear and a fault on the same edge: the new fault wins. Result is fault_sticky = 1, address/cause captured, fault_count = 1.
- Reset during activity: any pending response is discarded; rsp_valid = 0 on the cycle after reset.
- Requests with req_valid == 0 never affect state.

Optional Feature:
ALIGN_CHECK_EN
- Defined: a mapped, non-ROM-write request is misaligned when the low req_size address bits are nonzero, i.e. req_addr & ((1 << req_size) - 1) != 0. It then yields cause 3.
- Undefined: alignment is ignored, cause 3 is never produced, req_size is unused.

Decomposition:
- Package addr_check_pkg holds:
  - region codes: REG_NONE, REG_RAM, REG_ROM, REG_IO
  - cause codes: CAUSE_NONE, CAUSE_UNMAPPED, CAUSE_ROMWR, CAUSE_MISALIGN
  - size codes
- Sub-module region_match: combinational, parameters BASE, BITS, ADDR_WIDTH, output hit. Instantiated three times.

Test Plan:
- Reset held low 2 cycles, then a load at 0x40 -> next cycle rsp_valid = 1, region 1, fault 0. All outputs are 0 during reset.
- Load at 0x100 (bit 8 set) -> region 0, cause 1, fault_sticky = 1, fault_addr = 0x100, count = 1. Then a load at 0x8000_0000_0000_0000 -> count = 2, fault_addr still 0x100.
- Store at 0x1_0004 -> region 2, cause 2. Load at 0x1_0004 -> cause 0. Load at 0xF000_0000_0000_000C -> region 3.
- 300 back-to-back unmapped loads -> fault_count saturates at 255. fault_clear together with an unmapped load at 0x200 -> count = 1, fault_addr = 0x200.
- With ALIGN_CHECK_EN, a double load at 0x44 -> cause 3 and a double load at 0x48 -> cause 0. Without the macro, 0x44 -> cause 0.
- A request at 0x10 issued, then reset asserted on the next edge -> rsp_valid = 0 and the sticky record is 0 after reset.
